// File: rtl/config_chain_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
package fabric_cfg_pkg;

   localparam int unsigned CFG_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      SET,
      DONE
   } ld_state_e;

   // Width needed to hold 0..chain_len inclusive.
   function automatic int unsigned cnt_w(input int unsigned chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host word handshake into the configuration chain loader.
interface config_chain_loader_if
   import fabric_cfg_pkg::*;
#(
   parameter int unsigned WORD_W = CFG_WORD_W
);

   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output word_data,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/config_chain_loader_piso.sv
// Parallel-in serial-out word register, MSB first, with a last-bit flag.
module cfg_piso
   import fabric_cfg_pkg::*;
#(
   parameter int unsigned WORD_W = CFG_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   output logic              msb,
   output logic              last_bit
);

   localparam int unsigned BIT_W = $clog2(WORD_W);

   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [BIT_W-1:0]  bit_q, bit_d;

   assign msb      = sreg_q[WORD_W-1];
   assign last_bit = (bit_q == BIT_W'(WORD_W - 1));

   // Next-state: load wins over shift so a gapless reload replaces the spent word.
   always_comb begin
      sreg_d = sreg_q;
      bit_d  = bit_q;
      if (clear) begin
         sreg_d = '0;
         bit_d  = '0;
      end else if (load) begin
         sreg_d = data;
         bit_d  = '0;
      end else if (shift) begin
         sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
         bit_d  = last_bit ? '0 : bit_q + 1'b1;
      end
   end

   // Shift register and bit-position state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg_q <= '0;
         bit_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         bit_q  <= bit_d;
      end
   end

endmodule

// File: rtl/config_chain_loader.sv
// Feeds host config words MSB-first into the tile shift chain, then strobes set once.
module config_chain_loader
   import fabric_cfg_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 4096,
   parameter int unsigned WORD_W    = CFG_WORD_W,
   parameter int unsigned CNT_W     = cnt_w(CHAIN_LEN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   config_chain_loader_if.slave host,
   output logic                 cfg_shift,
   output logic                 cfg_en,
   output logic                 cfg_set,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     bits_left
);

   ld_state_e        state_q, state_d;
   logic [CNT_W-1:0] bits_q, bits_d;

   logic ready;
   logic en;
   logic set;
   logic piso_clear;
   logic piso_load;
   logic piso_shift;
   logic piso_msb;
   logic piso_last;

   cfg_piso #(
      .WORD_W (WORD_W)
   ) u_piso (
      .clk      (clk),
      .rst      (rst),
      .clear    (piso_clear),
      .load     (piso_load),
      .shift    (piso_shift),
      .data     (host.word_data),
      .msb      (piso_msb),
      .last_bit (piso_last)
   );

   // Next-state and per-state outputs; abort overrides everything at the end.
   always_comb begin
      state_d    = state_q;
      bits_d     = bits_q;
      ready      = 1'b0;
      en         = 1'b0;
      set        = 1'b0;
      piso_clear = 1'b0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = LOAD;
               bits_d     = CNT_W'(CHAIN_LEN);
               piso_clear = 1'b1;
            end
         end
         LOAD: begin
            ready = 1'b1;
            if (host.word_valid) begin
               piso_load = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            en         = 1'b1;
            piso_shift = 1'b1;
            if (bits_q != '0) begin
               bits_d = bits_q - 1'b1;
            end
            if (bits_q <= CNT_W'(1)) begin
               // Final chain bit: leftover low bits of the word are dropped.
               state_d = SET;
            end else if (piso_last) begin
               ready = 1'b1;
               if (host.word_valid) begin
                  piso_load = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         SET: begin
            set     = 1'b1;
            bits_d  = '0;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
            bits_d  = '0;
         end
      endcase

      if (abort) begin
         state_d    = IDLE;
         bits_d     = '0;
         piso_clear = 1'b1;
         piso_load  = 1'b0;
         piso_shift = 1'b0;
      end
   end

   // FSM state and remaining-bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bits_q  <= '0;
      end else begin
         state_q <= state_d;
         bits_q  <= bits_d;
      end
   end

   assign host.word_ready = ready;
   assign cfg_en          = en;
   assign cfg_shift       = en & piso_msb;
   assign cfg_set         = set;
   assign busy            = (state_q == LOAD) || (state_q == SHIFT) || (state_q == SET);
   assign done            = (state_q == DONE);
   assign bits_left       = bits_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench: three loader instances (chain 64, 40, 1) sharing clock and reset.
module tb_config_chain_loader;

   localparam int unsigned WW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    start_v;
   logic [2:0]    abort_v;
   logic [2:0]    valid_v;
   logic [WW-1:0] wdata;

   logic [2:0] en_v, sh_v, set_v, busy_v, done_v;
   logic [6:0] bl0;
   logic [5:0] bl1;
   logic [0:0] bl2;

   config_chain_loader_if #(.WORD_W(WW)) if0 ();
   config_chain_loader_if #(.WORD_W(WW)) if1 ();
   config_chain_loader_if #(.WORD_W(WW)) if2 ();

   assign if0.word_data  = wdata;
   assign if1.word_data  = wdata;
   assign if2.word_data  = wdata;
   assign if0.word_valid = valid_v[0];
   assign if1.word_valid = valid_v[1];
   assign if2.word_valid = valid_v[2];

   config_chain_loader #(.CHAIN_LEN(64), .WORD_W(WW)) u_dut64 (
      .clk (clk), .rst (rst_n), .start (start_v[0]), .abort (abort_v[0]), .host (if0.slave),
      .cfg_shift (sh_v[0]), .cfg_en (en_v[0]), .cfg_set (set_v[0]), .busy (busy_v[0]),
      .done (done_v[0]), .bits_left (bl0)
   );

   config_chain_loader #(.CHAIN_LEN(40), .WORD_W(WW)) u_dut40 (
      .clk (clk), .rst (rst_n), .start (start_v[1]), .abort (abort_v[1]), .host (if1.slave),
      .cfg_shift (sh_v[1]), .cfg_en (en_v[1]), .cfg_set (set_v[1]), .busy (busy_v[1]),
      .done (done_v[1]), .bits_left (bl1)
   );

   config_chain_loader #(.CHAIN_LEN(1), .WORD_W(WW)) u_dut1 (
      .clk (clk), .rst (rst_n), .start (start_v[2]), .abort (abort_v[2]), .host (if2.slave),
      .cfg_shift (sh_v[2]), .cfg_en (en_v[2]), .cfg_set (set_v[2]), .busy (busy_v[2]),
      .done (done_v[2]), .bits_left (bl2)
   );

   always #5 clk = ~clk;

   int   sel;
   logic s_en, s_shift, s_set, s_busy, s_done, s_ready;
   int   s_bits;

   always_comb begin
      s_en    = en_v[sel];
      s_shift = sh_v[sel];
      s_set   = set_v[sel];
      s_busy  = busy_v[sel];
      s_done  = done_v[sel];
      s_ready = 1'b0;
      s_bits  = 0;
      case (sel)
         0: begin s_ready = if0.word_ready; s_bits = int'(bl0); end
         1: begin s_ready = if1.word_ready; s_bits = int'(bl1); end
         default: begin s_ready = if2.word_ready; s_bits = int'(bl2); end
      endcase
   end

   function automatic int chain_len(input int s);
      case (s)
         0: return 64;
         1: return 40;
         default: return 1;
      endcase
   endfunction

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          c0;
   int          en_cnt, set_cnt, xfer_cnt, first_en, set_cyc, done_cyc;
   int          exp_budget;
   int          inv_viol = 0;
   bit          exp_q[$];
   logic [31:0] host_words[$];
   bit          host_en;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One clock: sample outputs at negedge, score shifted bits, then drive the host side.
   task automatic tick();
      logic        rdy;
      bit          e;
      logic [31:0] w;
      @(negedge clk);
      cyc++;
      if (s_en) begin
         en_cnt++;
         if (first_en < 0) first_en = cyc;
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("cfg_shift_bit", s_shift, e);
         end
      end else if (s_shift) begin
         inv_viol++;
      end
      if (s_set) begin
         set_cnt++;
         set_cyc = cyc;
         if (s_en || s_shift) inv_viol++;
      end
      if (s_done && done_cyc < 0) done_cyc = cyc;
      rdy     = s_ready;
      valid_v = '0;
      if (host_en && host_words.size() > 0) begin
         valid_v[sel] = 1'b1;
         wdata        = host_words[0];
      end
      if (valid_v[sel] && rdy) begin
         w = host_words.pop_front();
         xfer_cnt++;
         for (int i = 31; i >= 0; i--) begin
            if (exp_budget > 0) begin
               exp_q.push_back(w[i]);
               exp_budget--;
            end
         end
      end
   endtask

   // Pulse start on instance s; c0 marks the start cycle.
   task automatic begin_load(input int s);
      sel = s;
      exp_q.delete();
      exp_budget = chain_len(s);
      en_cnt     = 0;
      set_cnt    = 0;
      xfer_cnt   = 0;
      first_en   = -1;
      set_cyc    = -1;
      done_cyc   = -1;
      c0         = cyc;
      start_v    = '0;
      start_v[s] = 1'b1;
      tick();
      start_v = '0;
      check("bits_left_after_start", s_bits, chain_len(s));
      check("busy_in_load", s_busy, 1);
   endtask

   task automatic run_to_done(input int budget);
      int n;
      n = 0;
      while (done_cyc < 0 && n < budget) begin
         tick();
         n++;
      end
      if (done_cyc < 0) check("done_timeout", 0, 1);
   endtask

   typedef struct {
      int          s;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      int          busy_start_bits;
      int          exp_xfers;
      int          exp_en;
      int          exp_set_rel;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int  n;
      bit  pulsed;
      int  frozen;

      // Full loads: set lands 2 + CHAIN_LEN cycles after the start cycle.
      vecs[0] = '{s:0, w0:32'hA5A5_0001, w1:32'h8000_00FF, w2:32'hDEAD_BEEF,
                  busy_start_bits:0, exp_xfers:2, exp_en:64, exp_set_rel:66};
      vecs[1] = '{s:1, w0:32'hFFFF_FFFF, w1:32'hC300_0000, w2:32'h5A5A_5A5A,
                  busy_start_bits:0, exp_xfers:2, exp_en:40, exp_set_rel:42};
      vecs[2] = '{s:2, w0:32'h8000_0000, w1:32'h1234_5678, w2:32'h0,
                  busy_start_bits:0, exp_xfers:1, exp_en:1, exp_set_rel:3};
      vecs[3] = '{s:0, w0:32'h0123_4567, w1:32'hFEDC_BA98, w2:32'h0,
                  busy_start_bits:30, exp_xfers:2, exp_en:64, exp_set_rel:66};
      vecs[4] = '{s:2, w0:32'h7FFF_FFFF, w1:32'hFFFF_FFFF, w2:32'h0,
                  busy_start_bits:0, exp_xfers:1, exp_en:1, exp_set_rel:3};
      vecs[5] = '{s:1, w0:32'h0F0F_0F0F, w1:32'h3CFF_FFFF, w2:32'h0,
                  busy_start_bits:0, exp_xfers:2, exp_en:40, exp_set_rel:42};

      sel        = 0;
      rst_n      = 1'b0;
      start_v    = '0;
      abort_v    = '0;
      valid_v    = '0;
      wdata      = '0;
      host_en    = 1'b0;
      exp_budget = 0;
      en_cnt = 0; set_cnt = 0; xfer_cnt = 0;
      first_en = -1; set_cyc = -1; done_cyc = -1; c0 = 0;

      tick();
      tick();
      check("rst_cfg_en", s_en, 0);
      check("rst_cfg_set", s_set, 0);
      check("rst_busy", s_busy, 0);
      check("rst_done", s_done, 0);
      check("rst_bits_left", s_bits, 0);
      check("rst_word_ready", s_ready, 0);
      rst_n = 1'b1;
      tick();

      // Table-driven full loads.
      foreach (vecs[k]) begin
         host_words.delete();
         host_words.push_back(vecs[k].w0);
         host_words.push_back(vecs[k].w1);
         host_words.push_back(vecs[k].w2);
         host_en = 1'b1;
         begin_load(vecs[k].s);
         pulsed = 1'b0;
         n = 0;
         while (done_cyc < 0 && n < 200) begin
            tick();
            start_v = '0;
            if (vecs[k].busy_start_bits > 0 && !pulsed && s_bits == vecs[k].busy_start_bits) begin
               start_v[vecs[k].s] = 1'b1;
               pulsed = 1'b1;
            end
            n++;
         end
         if (done_cyc < 0) check("done_timeout", 0, 1);
         check("xfers", xfer_cnt, vecs[k].exp_xfers);
         check("en_cycles", en_cnt, vecs[k].exp_en);
         check("first_en_latency", first_en - c0, 2);
         check("set_latency", set_cyc - c0, vecs[k].exp_set_rel);
         check("set_pulses", set_cnt, 1);
         check("done_after_set", done_cyc - set_cyc, 1);
         check("sb_leftover", exp_q.size(), 0);
         check("busy_in_done", s_busy, 0);
         check("bits_left_in_done", s_bits, 0);
         host_en = 1'b0;
         repeat (3) tick();
         check("extra_word_untaken", xfer_cnt, vecs[k].exp_xfers);
      end

      // Host stalls after the first word: chain freezes with 32 bits left, then resumes.
      host_words.delete();
      host_words.push_back(32'h1234_5678);
      host_en = 1'b1;
      begin_load(0);
      repeat (40) tick();
      check("stall_en_count", en_cnt, 32);
      check("stall_cfg_en", s_en, 0);
      check("stall_bits_left", s_bits, 32);
      check("stall_busy", s_busy, 1);
      check("stall_ready", s_ready, 1);
      frozen = en_cnt;
      repeat (5) tick();
      check("stall_frozen", en_cnt, frozen);
      host_words.push_back(32'h9ABC_DEF0);
      run_to_done(80);
      check("stall_total_en", en_cnt, 64);
      check("stall_xfers", xfer_cnt, 2);
      check("stall_set_pulses", set_cnt, 1);
      check("stall_sb_leftover", exp_q.size(), 0);
      host_en = 1'b0;
      tick();

      // Abort with 17 bits left: back to idle, no set ever.
      host_words.delete();
      host_words.push_back(32'hCAFE_F00D);
      host_words.push_back(32'h0BAD_BEEF);
      host_en = 1'b1;
      begin_load(0);
      n = 0;
      while (s_bits != 17 && n < 100) begin
         tick();
         n++;
      end
      check("abort_reached_17", s_bits, 17);
      abort_v[0] = 1'b1;
      tick();
      abort_v = '0;
      check("abort_cfg_en", s_en, 0);
      check("abort_cfg_set", s_set, 0);
      check("abort_busy", s_busy, 0);
      check("abort_done", s_done, 0);
      check("abort_bits_left", s_bits, 0);
      host_en = 1'b0;
      repeat (10) tick();
      check("abort_no_set", set_cnt, 0);

      // New load after abort runs the full chain.
      host_words.delete();
      host_words.push_back(32'h1357_9BDF);
      host_words.push_back(32'h2468_ACE0);
      host_en = 1'b1;
      begin_load(0);
      run_to_done(100);
      check("post_abort_en", en_cnt, 64);
      check("post_abort_set", set_cnt, 1);
      host_en = 1'b0;
      tick();

      // start and abort together from DONE: abort wins.
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick();
      start_v = '0;
      abort_v = '0;
      check("start_abort_busy", s_busy, 0);
      check("start_abort_done", s_done, 0);
      check("start_abort_bits", s_bits, 0);

      // Asynchronous reset mid-shift.
      host_words.delete();
      host_words.push_back(32'hFFFF_FFFF);
      host_words.push_back(32'hFFFF_FFFF);
      host_en = 1'b1;
      begin_load(0);
      n = 0;
      while (s_bits != 50 && n < 100) begin
         tick();
         n++;
      end
      check("rst_mid_reached_50", s_bits, 50);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_cfg_en", s_en, 0);
      check("arst_cfg_shift", s_shift, 0);
      check("arst_cfg_set", s_set, 0);
      check("arst_busy", s_busy, 0);
      check("arst_done", s_done, 0);
      check("arst_bits_left", s_bits, 0);
      check("arst_word_ready", s_ready, 0);
      host_en = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("arst_no_set", set_cnt, 0);

      check("cfg_shift_without_en", inv_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
